agc_fetch_sequencer: RTL and testbench

- Upstream neighbour of the instruction decode stage.
- Owns the program counter Z and fetches 16-bit words (15 data bits plus an odd-parity bit) from erasable/fixed memory over a req/ack handshake.
- Checks parity and presents the 15-bit instruction to the decode stage with a valid/ready handshake plus a one-cycle timing pulse tp on which the decode stage registers its fields.
- Handles branch redirects, memory timeouts and parity alarms.

---
 rtl/agc_fetch_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_agc_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// agc_fetch_sequencer
//
// Purpose:
//   Owns the program counter Z and fetches instruction words from memory over
//   a level req / pulse ack handshake. Each 16-bit word carries 15 data bits
//   plus an odd-parity bit in [15]. A word that passes the parity check is
//   handed to the decode stage with a valid/ready handshake. A one-cycle tp
//   pulse marks the first cycle of each new instruction. The sequencer also
//   handles branch redirects, memory timeouts (retry of the same Z) and parity
//   alarms (fetching halts until a branch arrives).
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   mem_req      out  1   read request, held until mem_ack
//   mem_addr     out  12  read address, always equal to z
//   mem_ack      in   1   one-cycle ack, mem_rdata valid in the same cycle
//   mem_rdata    in   16  [15] parity, [14:0] word
//   instr        out  15  fetched instruction
//   instr_valid  out  1   instr holds an unconsumed instruction
//   instr_ready  in   1   decode stage accepts instr
//   tp           out  1   pulse on the first cycle of each new instr_valid
//   branch_en    in   1   one-cycle request to redirect Z
//   branch_addr  in   12  redirect target
//   z            out  12  address of the next/current fetch
//   parity_err   out  1   sticky parity alarm
//   timeout_err  out  1   sticky timeout alarm
// -----------------------------------------------------------------------------
module agc_fetch_sequencer #(
  parameter logic [11:0] RESET_Z        = 12'o4000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [14:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        tp,
  input  logic        branch_en,
  input  logic [11:0] branch_addr,
  output logic [11:0] z,
  output logic        parity_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_PERR    = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  // Odd parity: the XOR of all 16 bits must be 1 for a good word.
  function automatic logic f_parity_ok(input logic [15:0] word);
    return ^word;
  endfunction

  state_t      r_state;
  logic [11:0] r_z;
  logic        r_mem_req;
  logic [14:0] r_instr;
  logic        r_instr_valid;
  logic        r_tp;
  logic        r_parity_err;
  logic        r_timeout_err;
  logic        r_br_pend;
  logic [11:0] r_br_addr;
  logic [7:0]  r_tcnt;

  // A branch arriving in the same cycle as ack/timeout counts as pending too,
  // and the newest branch_en always overrides the stored target.
  logic        w_br_take;
  logic [11:0] w_br_target;
  logic        w_tmo_hit;

  assign w_br_take   = r_br_pend | branch_en;
  assign w_br_target = branch_en ? branch_addr : r_br_addr;
  assign w_tmo_hit   = ((r_tcnt + 8'd1) == TMO_LIMIT);

  // Fetch/present state machine with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_z           <= RESET_Z;
      r_mem_req     <= 1'b0;
      r_instr       <= 15'd0;
      r_instr_valid <= 1'b0;
      r_tp          <= 1'b0;
      r_parity_err  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_br_pend     <= 1'b0;
      r_br_addr     <= 12'd0;
      r_tcnt        <= 8'd0;
    end else begin
      // tp is only ever raised for the single cycle after a good ack.
      r_tp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (branch_en) begin
            // Redirect costs one more idle cycle before the fetch starts.
            r_z           <= branch_addr;
            r_instr_valid <= 1'b0;
          end else begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
            r_tcnt    <= 8'd0;
          end
        end

        S_FETCH: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_tcnt    <= 8'd0;
            r_br_pend <= 1'b0;
            if (w_br_take) begin
              // Word belongs to the abandoned path: discard it unchecked.
              r_z     <= w_br_target;
              r_state <= S_IDLE;
            end else if (f_parity_ok(mem_rdata)) begin
              r_instr       <= mem_rdata[14:0];
              r_instr_valid <= 1'b1;
              r_tp          <= 1'b1;
              r_z           <= r_z + 12'd1;
              r_state       <= S_PRESENT;
            end else begin
              r_parity_err <= 1'b1;
              r_state      <= S_PERR;
            end
          end else if (w_tmo_hit) begin
            // Drop the request for one idle cycle, then retry (or redirect).
            r_timeout_err <= 1'b1;
            r_tcnt        <= 8'd0;
            r_mem_req     <= 1'b0;
            r_br_pend     <= 1'b0;
            r_state       <= S_IDLE;
            if (w_br_take) begin
              r_z <= w_br_target;
            end
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
            if (branch_en) begin
              r_br_pend <= 1'b1;
              r_br_addr <= branch_addr;
            end
          end
        end

        S_PRESENT: begin
          // A branch together with ready still consumes the instruction.
          if (branch_en) begin
            r_z           <= branch_addr;
            r_instr_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end

        S_PERR: begin
          // Fetching stays halted; only a branch restarts it.
          if (branch_en) begin
            r_z     <= branch_addr;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_mem_req     <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_z;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign tp          = r_tp;
  assign z           = r_z;
  assign parity_err  = r_parity_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_agc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for agc_fetch_sequencer: a cycle table for reset/first fetch and
// the ready handshake, hand-written sequences for parity, timeout, branch and
// wrap corners, then a randomized run against a transaction-level model
// (expected fetch address stream plus a memory image).
// -----------------------------------------------------------------------------
module tb_agc_fetch_sequencer;

  localparam logic [11:0] RZ = 12'o4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'd0;
  logic [14:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        tp;
  logic        branch_en = 1'b0;
  logic [11:0] branch_addr = 12'd0;
  logic [11:0] z;
  logic        parity_err;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  agc_fetch_sequencer #(.RESET_Z(RZ), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .tp(tp),
    .branch_en(branch_en), .branch_addr(branch_addr), .z(z),
    .parity_err(parity_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        e_req;
    logic [11:0] e_z;
    logic [14:0] e_instr;
    logic        e_valid;
    logic        e_tp;
  } vec_t;

  vec_t vecs[11];

  // Build a memory word; good=1 gives odd overall parity.
  function automatic logic [15:0] gw(input logic [14:0] w, input bit good);
    logic p;
    p = good ? ~(^w) : (^w);
    return {p, w};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input logic [11:0] ea, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 40);
    chk({nm, "_req"}, 32'(mem_req), 32'd1);
    chk({nm, "_addr"}, 32'(mem_addr), 32'(ea));
  endtask

  // Reset, then redirect from IDLE so the first fetch happens at target.
  task automatic restart_at(input logic [11:0] target);
    mem_ack = 1'b0; instr_ready = 1'b0; branch_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    branch_en = 1'b1; branch_addr = target;
    @(negedge clk);
    branch_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mem [4096];
    logic [15:0] w;
    int n;
    bit seen_tp;
    int wt, dly, delivered;
    bit was_req, acked, exp_to, pv;
    logic [11:0] ea;
    logic [14:0] held;

    // Reset + first fetch + 5-cycle ready stall + handshake latency.
    w = gw(15'o65421, 1'b1);
    vecs[0]  = '{1'b0, 16'd0, 1'b0, 1'b0, 12'o4000, 15'd0,     1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'd0, 1'b0, 1'b1, 12'o4000, 15'd0,     1'b0, 1'b0};
    vecs[2]  = '{1'b1, w,     1'b0, 1'b1, 12'o4000, 15'd0,     1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'd0, 1'b0, 1'b0, 12'o4001, 15'o65421, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 16'd0, 1'b0, 1'b0, 12'o4001, 15'o65421, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'd0, 1'b0, 1'b0, 12'o4001, 15'o65421, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'd0, 1'b0, 1'b0, 12'o4001, 15'o65421, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'd0, 1'b0, 1'b0, 12'o4001, 15'o65421, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 16'd0, 1'b1, 1'b0, 12'o4001, 15'o65421, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'd0, 1'b0, 1'b0, 12'o4001, 15'o65421, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'd0, 1'b0, 1'b1, 12'o4001, 15'o65421, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_z", 32'(z), 32'(RZ));
    chk("rst_addr", 32'(mem_addr), 32'(RZ));
    chk("rst_out", {28'd0, instr_valid, tp, parity_err, timeout_err}, 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);

    // The edge at which reset drops counts as posedge 1; mem_req rises on 2.
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {28'd0, mem_req, instr_valid, tp, 1'b0},
          {28'd0, vecs[i].e_req, vecs[i].e_valid, vecs[i].e_tp, 1'b0});
      chk($sformatf("vec%0d_z", i), {8'd0, z, mem_addr}, {8'd0, vecs[i].e_z, vecs[i].e_z});
      if (vecs[i].e_valid) chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].e_instr));
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata; instr_ready = vecs[i].ready;
    end

    // Even-parity word: alarm, no delivery, fetching halts until a branch.
    restart_at(12'o0100);
    wait_req(12'o0100, "par_fetch");
    mem_ack = 1'b1; mem_rdata = gw(15'o12345, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("par_err", 32'(parity_err), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req || instr_valid || tp) n++;
      @(negedge clk);
    end
    chk("par_halt", 32'(n), 32'd0);
    chk("par_z", 32'(z), 32'o0100);
    branch_en = 1'b1; branch_addr = 12'o2000;
    @(negedge clk);
    branch_en = 1'b0;
    chk("par_sticky", 32'(parity_err), 32'd1);
    wait_req(12'o2000, "par_resume");

    // Timeout: 15 request cycles without ack, one idle cycle, same-z retry.
    restart_at(12'o0007);
    wait_req(12'o0007, "tmo_fetch");
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    chk("tmo_len", 32'(n), 32'd15);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    @(negedge clk);
    chk("tmo_retry", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, 12'o0007});
    mem_ack = 1'b1; mem_rdata = gw(15'o70707, 1'b1);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("tmo_deliver", {16'd0, tp, instr_valid, instr[13:0]}, {16'd0, 1'b1, 1'b1, 14'(15'o70707)});
    chk("tmo_instr", 32'(instr), 32'o70707);
    chk("tmo_z", 32'(z), 32'o0010);

    // Branch while fetching: the acked word is discarded, refetch at target.
    restart_at(12'o0500);
    wait_req(12'o0500, "brf_fetch");
    branch_en = 1'b1; branch_addr = 12'o3000;
    seen_tp = 1'b0;
    @(negedge clk);
    branch_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seen_tp |= tp | instr_valid;
      @(negedge clk);
    end
    chk("brf_held_req", {20'd0, mem_req, mem_addr}, {20'd0, 1'b1, 12'o0500});
    mem_ack = 1'b1; mem_rdata = gw(15'o11111, 1'b1);
    @(negedge clk);
    mem_ack = 1'b0;
    seen_tp |= tp | instr_valid;
    chk("brf_discard", 32'(seen_tp), 32'd0);
    chk("brf_z", 32'(z), 32'o3000);
    wait_req(12'o3000, "brf_refetch");

    // Wrap at 7777, then branch coincident with ready.
    restart_at(12'o7777);
    wait_req(12'o7777, "wrap_fetch");
    mem_ack = 1'b1; mem_rdata = gw(15'o22222, 1'b1);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("wrap_z", 32'(z), 32'd0);
    chk("wrap_instr", {15'd0, tp, 1'b0, instr}, {15'd0, 1'b1, 1'b0, 15'o22222});
    instr_ready = 1'b1; branch_en = 1'b1; branch_addr = 12'o1234;
    @(negedge clk);
    instr_ready = 1'b0; branch_en = 1'b0;
    chk("brr_consumed", {30'd0, instr_valid, tp}, 32'd0);
    chk("brr_z", 32'(z), 32'o1234);
    @(negedge clk);
    chk("brr_fetch", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, 12'o1234});

    // Randomized run: expected fetch stream is sequential from RESET_Z,
    // replaced by the target whenever a branch hits a presented instruction.
    for (int i = 0; i < 4096; i++) mem[i] = gw(15'($urandom), 1'b1);
    mem_ack = 1'b0; instr_ready = 1'b0; branch_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ea = RZ; wt = 0; dly = 2; delivered = 0;
    was_req = 1'b0; acked = 1'b0; exp_to = 1'b0; pv = 1'b0; held = 15'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (tp) begin
        chk("rnd_instr", 32'(instr), 32'(mem[ea][14:0]));
        ea = ea + 12'd1;
        delivered++;
        held = instr;
      end
      chk("rnd_tp", 32'(tp), 32'(instr_valid && !pv));
      if (instr_valid && pv) chk("rnd_hold", 32'(instr), 32'(held));
      pv = instr_valid;

      mem_ack = 1'b0;
      if (mem_req) begin
        if (wt == dly) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          chk("rnd_addr", 32'(mem_addr), 32'(ea));
          acked = 1'b1;
        end
        wt++;
        was_req = 1'b1;
      end else begin
        if (was_req && !acked) begin
          chk("rnd_tmo_len", 32'(wt), 32'd15);
          exp_to = 1'b1;
        end
        was_req = 1'b0; acked = 1'b0; wt = 0;
        dly = ($urandom % 8 == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(0, 5));
      end
      chk("rnd_tmo_flag", 32'(timeout_err), 32'(exp_to));

      if (instr_valid) begin
        instr_ready = ($urandom % 3 == 0);
        branch_en = ($urandom % 8 == 0);
        if (branch_en) begin
          branch_addr = 12'($urandom);
          ea = branch_addr;
        end
      end else begin
        instr_ready = 1'b0;
        branch_en = 1'b0;
      end
    end
    mem_ack = 1'b0; instr_ready = 1'b0; branch_en = 1'b0;
    chk("rnd_parity_clean", 32'(parity_err), 32'd0);
    chk("rnd_progress", 32'(delivered > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
